// File: rtl/pulse_scheduler_pkg.sv
// Shared types and helpers for the pulse scheduler: FSM state encoding and
// the counter-width calculation used by the top level.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } pulse_sched_state_t;

    // Counter must hold PULSE_LEN-1 and GAP_LEN-1; a width of at least 1 is guaranteed.
    function automatic int cnt_width(input int pulse_len, input int gap_len);
        int max_len;
        max_len = (pulse_len > gap_len) ? pulse_len : gap_len;
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pulse_scheduler_if.sv
// Requester-side bundle of the pulse scheduler: triggers in, shared strobe and
// per-requester status out. The scheduler uses the slave modport.
interface pulse_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] trigger;
    logic               pulse;
    logic [IDX_W-1:0]   pulse_owner;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] pending;
    logic               busy;
    logic [NUM_REQ-1:0] overrun;

    modport master (
        output trigger,
        input  pulse, pulse_owner, done, pending, busy, overrun
    );

    modport slave (
        input  trigger,
        output pulse, pulse_owner, done, pending, busy, overrun
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or above ptr, with wrap.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest request is written last and wins.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one timed strobe among NUM_REQ requesters: edge-detected requests, round-robin grants,
// fixed-width pulse plus guard gap. Optional sticky drop flags: PULSE_SCHEDULER_OVERRUN_EN.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int PULSE_LEN = 10,
    parameter  int GAP_LEN   = 2,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = cnt_width(PULSE_LEN, GAP_LEN)
) (
    input logic              clk,
    input logic              reset_n,
    pulse_scheduler_if.slave bus
);

    pulse_sched_state_t state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] trigger_d;
    logic [NUM_REQ-1:0] pending, pending_n;
    logic [NUM_REQ-1:0] done_q, done_n;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] trig_edge;
    logic               pulse_q, pulse_n;
    logic [IDX_W-1:0]   owner_q, owner_n;
    logic [IDX_W-1:0]   rr_ptr, rr_n;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

    assign trig_edge = bus.trigger & ~trigger_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (pending),
        .ptr         (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        owner_n = owner_q;
        done_n  = '0;
        clr     = '0;
        rr_n    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_n        = PULSE;
                    pulse_n        = 1'b1;
                    owner_n        = grant_idx;
                    clr[grant_idx] = 1'b1;
                    cnt_n          = CNT_W'(PULSE_LEN - 1);
                    rr_n           = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_n   = cnt - CNT_W'(1);
                    pulse_n = 1'b1;
                end else begin
                    done_n[owner_q] = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_n = GAP;
                        cnt_n   = CNT_W'(GAP_LEN - 1);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt != '0) cnt_n = cnt - CNT_W'(1);
                else           state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A new edge in the grant cycle re-queues the requester: set wins over clear.
        pending_n = (pending & ~clr) | trig_edge;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            trigger_d <= '0;
            pending   <= '0;
            done_q    <= '0;
            pulse_q   <= 1'b0;
            owner_q   <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            trigger_d <= bus.trigger;
            pending   <= pending_n;
            done_q    <= done_n;
            pulse_q   <= pulse_n;
            owner_q   <= owner_n;
            rr_ptr    <= rr_n;
        end
    end

`ifdef PULSE_SCHEDULER_OVERRUN_EN
    logic [NUM_REQ-1:0] overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun_q <= '0;
        else          overrun_q <= overrun_q | (trig_edge & pending & ~clr);
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = '0;
`endif

    assign bus.pulse       = pulse_q;
    assign bus.pulse_owner = owner_q;
    assign bus.done        = done_q;
    assign bus.pending     = pending;
    assign bus.busy        = (state != IDLE);

endmodule
